// File: rtl/three_parallel_pkg.sv
// ---------------------------------------------------------------------------
// three_parallel_pkg
// Types and constants shared between the 3-parallel FIR filter top and its
// output serializer.
//   LANES   : samples per parallel block (lane 0 = oldest)
//   ACC_W   : default accumulator width of each lane
//   acc_t   : one signed lane accumulator
//   block_t : one block of LANES accumulators
//   lane_e  : lane index walked by the serializer
// ---------------------------------------------------------------------------
package three_parallel_pkg;

    localparam int LANES = 3;
    localparam int ACC_W = 64;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef acc_t block_t [LANES];

    typedef enum logic [1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2
    } lane_e;

endpackage

// File: rtl/three_parallel_serializer_quantizer.sv
// ---------------------------------------------------------------------------
// sample_quantizer
// Combinational round-half-up and saturate from the wide accumulator width
// down to the output sample width.
//   i_acc    : signed accumulator, IN_W bits
//   o_sample : rounded, saturated sample, OUT_W bits
//   o_sat    : 1 when o_sample was clipped to a rail
// ---------------------------------------------------------------------------
module sample_quantizer #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15
) (
    input  logic signed [IN_W-1:0]  i_acc,
    output logic signed [OUT_W-1:0] o_sample,
    output logic                    o_sat
);

    // One guard bit so adding the rounding constant can never overflow.
    localparam logic signed [IN_W:0] MAXV = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MINV = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0] w_ext;
    logic signed [IN_W:0] w_t;

    assign w_ext = {i_acc[IN_W-1], i_acc};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [IN_W:0] ROUND = (IN_W+1)'(1) << (SHIFT-1);
            assign w_t = (w_ext + ROUND) >>> SHIFT;
        end else begin : g_pass
            assign w_t = w_ext;
        end
    endgenerate

    // NOTE: every output gets a default first so no path through the
    // block leaves it unassigned (which would infer a latch).
    always_comb begin
        o_sat    = 1'b0;
        o_sample = w_t[OUT_W-1:0];
        if (w_t > MAXV) begin
            o_sample = {1'b0, {(OUT_W-1){1'b1}}};
            o_sat    = 1'b1;
        end else if (w_t < MINV) begin
            o_sample = {1'b1, {(OUT_W-1){1'b0}}};
            o_sat    = 1'b1;
        end
    end

endmodule

// File: rtl/three_parallel_serializer.sv
// ---------------------------------------------------------------------------
// three_parallel_serializer
// Output end of the 3-parallel FIR datapath. Buffers up to two blocks of
// three lanes and emits them one quantized sample per cycle, lane 0 first.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : block handshake for din0..din2
//   din0..din2          : signed lanes, din0 oldest
//   out_valid/out_ready : serial sample handshake
//   dout, out_lane      : quantized sample and the lane it came from
//   sat_flag            : sticky, set once any emitted sample saturated
// ---------------------------------------------------------------------------
module three_parallel_serializer
    import three_parallel_pkg::*;
#(
    parameter int IN_W  = ACC_W,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  din0,
    input  logic signed [IN_W-1:0]  din1,
    input  logic signed [IN_W-1:0]  din2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] dout,
    output logic [1:0]              out_lane,
    output logic                    sat_flag
);

    localparam int DEPTH = 2;

    logic signed [IN_W-1:0] r_mem [DEPTH][LANES];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;
    lane_e                  r_lane;

    logic signed [OUT_W-1:0] r_dout;
    logic [1:0]              r_out_lane;
    logic                    r_out_valid;
    logic                    r_sat_flag;

    logic                    w_push;
    logic                    w_adv;
    logic                    w_pop;
    logic signed [IN_W-1:0]  w_head;
    logic signed [OUT_W-1:0] w_q;
    logic                    w_q_sat;

    // in_ready depends only on the occupancy register, never on out_ready.
    assign in_ready = (r_count != 2'd2);
    assign w_push   = in_valid && in_ready;
    // Output register takes the next lane whenever it is empty or draining.
    assign w_adv    = (!r_out_valid || out_ready) && (r_count != 2'd0);
    // Head block leaves the FIFO on the edge that loads its last lane.
    assign w_pop    = w_adv && (r_lane == LANE2);
    assign w_head   = r_mem[r_rd_ptr][r_lane];

    sample_quantizer #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_quant (
        .i_acc    (w_head),
        .o_sample (w_q),
        .o_sat    (w_q_sat)
    );

    // NOTE: block storage has no reset; entries are only read when r_count
    // says they were written, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr][0] <= din0;
            r_mem[r_wr_ptr][1] <= din1;
            r_mem[r_wr_ptr][2] <= din2;
        end
    end

    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_lane   <= LANE0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Simultaneous accept and retire leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_adv) begin
                case (r_lane)
                    LANE0:   r_lane <= LANE1;
                    LANE1:   r_lane <= LANE2;
                    default: r_lane <= LANE0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout      <= '0;
            r_out_lane  <= 2'd0;
            r_out_valid <= 1'b0;
            r_sat_flag  <= 1'b0;
        end else begin
            if (w_adv) begin
                r_dout      <= w_q;
                r_out_lane  <= r_lane;
                r_out_valid <= 1'b1;
                if (w_q_sat) begin
                    r_sat_flag <= 1'b1;
                end
            end else if (out_ready) begin
                // Last sample consumed with nothing buffered behind it.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign dout      = r_dout;
    assign out_lane  = r_out_lane;
    assign out_valid = r_out_valid;
    assign sat_flag  = r_sat_flag;

endmodule
